// File: rtl/ahb_subordinate_responder_if.sv
// rtl/ahb_subordinate_responder_if.sv - AHB-Lite responder bus bundle; exclusive signals present with AHB_SUB_EXCL_EN
interface ahb_subordinate_responder_if #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32
`ifdef AHB_SUB_EXCL_EN
   ,parameter int HMASTER_WIDTH = 4
`endif
);
    logic                    HSEL;
    logic [ADDR_WIDTH-1:0]   HADDR;
    logic [1:0]              HTRANS;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic [DATA_WIDTH-1:0]   HWDATA;
    logic [DATA_WIDTH/8-1:0] HWSTRB;
    logic                    HREADY;
    logic [DATA_WIDTH-1:0]   HRDATA;
    logic                    HREADYOUT;
    logic                    HRESP;
`ifdef AHB_SUB_EXCL_EN
    logic                     HEXCL;
    logic [HMASTER_WIDTH-1:0] HMASTER;
    logic                     HEXOKAY;
`endif

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB, HREADY,
`ifdef AHB_SUB_EXCL_EN
        output HEXCL, HMASTER, input HEXOKAY,
`endif
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB, HREADY,
`ifdef AHB_SUB_EXCL_EN
        input  HEXCL, HMASTER, output HEXOKAY,
`endif
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_subordinate_responder.sv
// rtl/ahb_subordinate_responder.sv - AHB-Lite memory responder with wait states, ERROR responses; AHB_SUB_EXCL_EN adds exclusive monitor
module ahb_subordinate_responder #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH     = 256,
    parameter int WAIT_STATES   = 1,
    parameter int HMASTER_WIDTH = 4
) (
    input logic                    HCLK,
    input logic                    HRESETn,
    ahb_subordinate_responder_if.slave bus
);
    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(STRB_W);
    localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 dphase_q, dphase_d;
    logic [MEM_AW-1:0]    word_q, word_d;
    logic [LANE_BITS-1:0] lane_q, lane_d;
    logic [2:0]           size_q, size_d;
    logic                 write_q, write_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept;
    logic                  addr_err;
    logic                  complete;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] word_full;
    logic [STRB_W-1:0]     lane_mask;
    logic [STRB_W-1:0]     wr_en;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  unused_bits;

    // An address phase is only taken when the previous data phase is finishing (or there is none).
    assign accept   = ((state_q == ST_IDLE) || (state_q == ST_ERR2)) &&
                      bus.HSEL && bus.HREADY && bus.HTRANS[1];
    // IDLE with a pending OKAY data phase is the cycle in which that phase completes.
    assign complete = (state_q == ST_IDLE) && dphase_q;

    // Address-phase decode: out-of-range word, oversize transfer, or misaligned address.
    always_comb begin
        word_full = bus.HADDR >> LANE_BITS;
        addr_err  = (word_full >= ADDR_WIDTH'(MEM_DEPTH));
        if (bus.HSIZE > 3'(LANE_BITS)) begin
            addr_err = 1'b1;
        end
        for (int i = 0; i < LANE_BITS; i++) begin
            if ((i < int'(bus.HSIZE)) && bus.HADDR[i]) begin
                addr_err = 1'b1;
            end
        end
    end

    // Byte lanes touched by the registered size/offset.
    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < STRB_W; b++) begin
            lane_mask[b] = (b >= int'(lane_q)) && (b < int'(lane_q) + (1 << size_q));
        end
    end

    assign wr_en = lane_mask & bus.HWSTRB;

`ifdef AHB_SUB_EXCL_EN
    logic                     excl_q, excl_d;
    logic [HMASTER_WIDTH-1:0] master_q, master_d;
    logic                     mon_valid_q, mon_valid_d;
    logic [HMASTER_WIDTH-1:0] mon_master_q, mon_master_d;
    logic [MEM_AW-1:0]        mon_word_q, mon_word_d;
    logic                     excl_match;

    assign excl_match  = mon_valid_q && (mon_master_q == master_q) && (mon_word_q == word_q);
    // A failed exclusive write still completes OKAY but leaves memory untouched.
    assign commit      = complete && write_q && (!excl_q || excl_match);
    assign bus.HEXOKAY = complete && excl_q && (!write_q || excl_match);
    assign unused_bits = bus.HTRANS[0];

    // Single-entry monitor: exclusive reads arm it, any write landing on the word disarms it.
    always_comb begin
        excl_d       = excl_q;
        master_d     = master_q;
        mon_valid_d  = mon_valid_q;
        mon_master_d = mon_master_q;
        mon_word_d   = mon_word_q;
        if (accept) begin
            excl_d   = bus.HEXCL;
            master_d = bus.HMASTER;
        end
        if (complete && excl_q && !write_q) begin
            mon_valid_d  = 1'b1;
            mon_master_d = master_q;
            mon_word_d   = word_q;
        end
        if (commit && mon_valid_q && (mon_word_q == word_q)) begin
            mon_valid_d = 1'b0;
        end
    end

    // Exclusive bookkeeping registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            excl_q       <= 1'b0;
            master_q     <= '0;
            mon_valid_q  <= 1'b0;
            mon_master_q <= '0;
            mon_word_q   <= '0;
        end else begin
            excl_q       <= excl_d;
            master_q     <= master_d;
            mon_valid_q  <= mon_valid_d;
            mon_master_q <= mon_master_d;
            mon_word_q   <= mon_word_d;
        end
    end
`else
    assign commit      = complete && write_q;
    assign unused_bits = bus.HTRANS[0] ^ HMASTER_WIDTH[0];
`endif

    // Data-phase sequencing: wait-state countdown and the two-cycle ERROR response.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dphase_d = dphase_q;
        word_d   = word_q;
        lane_d   = lane_q;
        size_d   = size_q;
        write_d  = write_q;
        unique case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d  = ST_IDLE;
                dphase_d = 1'b0;
                if (accept) begin
                    word_d  = bus.HADDR[LANE_BITS +: MEM_AW];
                    lane_d  = bus.HADDR[LANE_BITS-1:0];
                    size_d  = bus.HSIZE;
                    write_d = bus.HWRITE;
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d  = ST_WAIT;
                        cnt_d    = WAIT_INIT;
                        dphase_d = 1'b1;
                    end else begin
                        dphase_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d  = ST_IDLE;
                dphase_d = 1'b0;
            end
        endcase
    end

    // Control and address registers; reset aborts any data phase in flight.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            dphase_q <= 1'b0;
            word_q   <= '0;
            lane_q   <= '0;
            size_q   <= 3'd0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dphase_q <= dphase_d;
            word_q   <= word_d;
            lane_q   <= lane_d;
            size_q   <= size_d;
            write_q  <= write_d;
        end
    end

    // Byte-masked write at the edge that ends the completing cycle; storage is not reset.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_en[b]) begin
                    mem[word_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Read data is driven only in the completing cycle of a read.
    always_comb begin
        hrdata = '0;
        if (complete && !write_q) begin
            hrdata = mem[word_q];
        end
    end

    assign bus.HRDATA    = hrdata;
    assign bus.HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    assign bus.HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
endmodule

// File: tb/tb_ahb_subordinate_responder.sv
// tb/tb_ahb_subordinate_responder.sv - scoreboard bench for ahb_subordinate_responder (WAIT_STATES 0 and 1)
module tb_ahb_subordinate_responder;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int K_WR = 0, K_RD = 1, K_ERR = 2, K_IDLE = 3;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;

    typedef struct {
        int          kind;
        logic [31:0] rdata;
        int          stalls;
        logic        exok;
        string       nm;
    } exp_t;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    int          cur = 1;
    logic        d_hsel = 1'b0;
    logic [1:0]  d_htrans = T_IDLE;
    logic [31:0] d_haddr = '0;
    logic        d_hwrite = 1'b0;
    logic [2:0]  d_hsize = 3'd0;
    logic [31:0] d_hwdata = '0;
    logic [3:0]  d_hwstrb = '0;
    logic        t_excl = 1'b0;
    logic [3:0]  t_master = 4'd0;
    logic        t_exok = 1'b0;

    int   n_total = 0;
    int   n_pass = 0;
    exp_t sb[$];
    exp_t me;
    int   stall_n = 0;
    logic first_resp = 1'b0;

`ifdef AHB_SUB_EXCL_EN
    ahb_subordinate_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HMASTER_WIDTH(4)) bus0 ();
    ahb_subordinate_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HMASTER_WIDTH(4)) bus1 ();
    assign bus0.HEXCL = t_excl;  assign bus0.HMASTER = t_master;
    assign bus1.HEXCL = t_excl;  assign bus1.HMASTER = t_master;
`else
    ahb_subordinate_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    ahb_subordinate_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
`endif

    assign bus0.HSEL = d_hsel && (cur == 0);  assign bus1.HSEL = d_hsel && (cur == 1);
    assign bus0.HADDR = d_haddr;              assign bus1.HADDR = d_haddr;
    assign bus0.HTRANS = d_htrans;            assign bus1.HTRANS = d_htrans;
    assign bus0.HWRITE = d_hwrite;            assign bus1.HWRITE = d_hwrite;
    assign bus0.HSIZE = d_hsize;              assign bus1.HSIZE = d_hsize;
    assign bus0.HWDATA = d_hwdata;            assign bus1.HWDATA = d_hwdata;
    assign bus0.HWSTRB = d_hwstrb;            assign bus1.HWSTRB = d_hwstrb;
    assign bus0.HREADY = bus0.HREADYOUT;      assign bus1.HREADY = bus1.HREADYOUT;

    ahb_subordinate_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(256),
        .WAIT_STATES(0), .HMASTER_WIDTH(4)) u_dut0 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0));
    ahb_subordinate_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(256),
        .WAIT_STATES(1), .HMASTER_WIDTH(4)) u_dut1 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1));

    logic        m_ready, m_resp;
    logic [31:0] m_rdata;
    assign m_ready = (cur == 1) ? bus1.HREADYOUT : bus0.HREADYOUT;
    assign m_resp  = (cur == 1) ? bus1.HRESP     : bus0.HRESP;
    assign m_rdata = (cur == 1) ? bus1.HRDATA    : bus0.HRDATA;
`ifdef AHB_SUB_EXCL_EN
    logic m_exok;
    assign m_exok = (cur == 1) ? bus1.HEXOKAY : bus0.HEXOKAY;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge HCLK);
        while (!m_ready && n < 40) begin
            n++;
            @(negedge HCLK);
        end
        if (!m_ready) begin
            n_total++;
            $display("FAIL ready_timeout: HREADYOUT low for %0d cycles, required high", n);
        end
        @(posedge HCLK);
        #1;
    endtask

    // Drive one address phase, wait for acceptance, then drive its data phase and queue the expectation.
    task automatic xfer(input logic sel, input logic [1:0] tr, input logic [31:0] a, input logic wr,
                        input logic [2:0] sz, input logic [31:0] wd, input logic [3:0] st,
                        input int kind, input logic [31:0] rd, input string nm);
        exp_t e;
        d_hsel = sel; d_htrans = tr; d_haddr = a; d_hwrite = wr; d_hsize = sz;
        wait_ready();
        d_hwdata = wd; d_hwstrb = st;
        e.kind = kind; e.rdata = rd; e.nm = nm; e.exok = t_exok;
        e.stalls = (kind == K_WR || kind == K_RD) ? ((cur == 1) ? 1 : 0) : ((kind == K_ERR) ? 1 : 0);
        sb.push_back(e);
    endtask

    task automatic drain();
        t_excl = 1'b0; t_exok = 1'b0;
        xfer(1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0, 4'h0, K_IDLE, 32'h0, "idle");
        @(negedge HCLK);
        #1;
        chk("scoreboard drained", sb.size(), 0);
    endtask

    // Monitor: count stall cycles of the oldest outstanding phase and check it when HREADYOUT rises.
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            stall_n = 0;
        end else if (sb.size() > 0) begin
            if (!m_ready) begin
                if (stall_n == 0) first_resp = m_resp;
                stall_n++;
            end else begin
                me = sb.pop_front();
                chk({me.nm, " stalls"}, stall_n, me.stalls);
                chk({me.nm, " hresp"}, {31'b0, m_resp}, (me.kind == K_ERR) ? 1 : 0);
                if (me.kind == K_ERR) chk({me.nm, " err1 hresp"}, {31'b0, first_resp}, 1);
                chk({me.nm, " hrdata"}, m_rdata, (me.kind == K_RD) ? me.rdata : 32'h0);
`ifdef AHB_SUB_EXCL_EN
                chk({me.nm, " hexokay"}, {31'b0, m_exok}, {31'b0, me.exok});
`endif
                stall_n = 0;
            end
        end
    end

    initial begin
        #2;
        chk("reset hreadyout", {31'b0, bus1.HREADYOUT}, 1);
        chk("reset hresp", {31'b0, bus1.HRESP}, 0);
        chk("reset hrdata", bus1.HRDATA, 0);
        chk("reset hreadyout ws0", {31'b0, bus0.HREADYOUT}, 1);
`ifdef AHB_SUB_EXCL_EN
        chk("reset hexokay", {31'b0, bus1.HEXOKAY}, 0);
`endif
        @(negedge HCLK); @(negedge HCLK);
        HRESETn = 1'b1;

        // WAIT_STATES=0 instance: no stalls on OKAY, ERROR still two cycles
        cur = 0;
        xfer(1, T_NS, 32'h10, 1, 3'd2, 32'hDEADBEEF, 4'hF, K_WR, 0, "ws0 wr 0x10");
        xfer(1, T_NS, 32'h11, 1, 3'd0, 32'h0000AB00, 4'hF, K_WR, 0, "ws0 wrb 0x11");
        xfer(1, T_NS, 32'h10, 0, 3'd2, 32'h0, 4'h0, K_RD, 32'hDEADABEF, "ws0 rd 0x10");
        xfer(1, T_NS, 32'h400, 0, 3'd2, 32'h0, 4'h0, K_ERR, 0, "ws0 rd 0x400");
        drain();

        // WAIT_STATES=1 instance
        cur = 1;
        xfer(1, T_NS, 32'h00, 1, 3'd2, 32'h5A5A5A5A, 4'hF, K_WR, 0, "wr 0x00");
        xfer(1, T_NS, 32'h1C, 1, 3'd2, 32'h11111111, 4'hF, K_WR, 0, "wr 0x1C");
        xfer(1, T_NS, 32'h30, 1, 3'd2, 32'hCAFEF00D, 4'hF, K_WR, 0, "wr 0x30");
        xfer(1, T_NS, 32'h10, 1, 3'd2, 32'hDEADBEEF, 4'hF, K_WR, 0, "wr 0x10");
        xfer(1, T_NS, 32'h10, 0, 3'd2, 32'h0, 4'h0, K_RD, 32'hDEADBEEF, "rd 0x10");
        xfer(1, T_NS, 32'h11, 1, 3'd0, 32'h0000AB00, 4'hF, K_WR, 0, "wrb 0x11");
        xfer(1, T_NS, 32'h10, 0, 3'd2, 32'h0, 4'h0, K_RD, 32'hDEADABEF, "rd 0x10 after byte");
        xfer(1, T_NS, 32'h00, 1, 3'd2, 32'hFFFF1234, 4'h3, K_WR, 0, "wr 0x00 strb3");
        xfer(1, T_NS, 32'h1E, 1, 3'd1, 32'hBEEF0000, 4'hF, K_WR, 0, "wrh 0x1E");
        xfer(1, T_NS, 32'h400, 0, 3'd2, 32'h0, 4'h0, K_ERR, 0, "rd 0x400");
        xfer(1, T_NS, 32'h02, 1, 3'd2, 32'hFFFFFFFF, 4'hF, K_ERR, 0, "wr 0x02 misaligned");
        xfer(1, T_NS, 32'h00, 0, 3'd3, 32'h0, 4'h0, K_ERR, 0, "rd dword 0x00");
        xfer(1, T_NS, 32'h00, 0, 3'd2, 32'h0, 4'h0, K_RD, 32'h5A5A1234, "rd 0x00");
        xfer(1, T_NS, 32'h1C, 0, 3'd2, 32'h0, 4'h0, K_RD, 32'hBEEF1111, "rd 0x1C");

        // INCR4 with a BUSY after beat 2, then an unselected NONSEQ write
        xfer(1, T_NS,   32'h20, 1, 3'd2, 32'hA0A0A0A0, 4'hF, K_WR, 0, "incr b0");
        xfer(1, T_SEQ,  32'h24, 1, 3'd2, 32'hA1A1A1A1, 4'hF, K_WR, 0, "incr b1");
        xfer(1, T_BUSY, 32'h28, 1, 3'd2, 32'h0, 4'hF, K_IDLE, 0, "incr busy");
        xfer(1, T_SEQ,  32'h28, 1, 3'd2, 32'hA2A2A2A2, 4'hF, K_WR, 0, "incr b2");
        xfer(1, T_SEQ,  32'h2C, 1, 3'd2, 32'hA3A3A3A3, 4'hF, K_WR, 0, "incr b3");
        xfer(0, T_NS,   32'h1C, 1, 3'd2, 32'hFFFFFFFF, 4'hF, K_IDLE, 0, "unselected wr");
        xfer(1, T_NS, 32'h20, 0, 3'd2, 32'h0, 4'h0, K_RD, 32'hA0A0A0A0, "rd 0x20");
        xfer(1, T_NS, 32'h24, 0, 3'd2, 32'h0, 4'h0, K_RD, 32'hA1A1A1A1, "rd 0x24");
        xfer(1, T_NS, 32'h28, 0, 3'd2, 32'h0, 4'h0, K_RD, 32'hA2A2A2A2, "rd 0x28");
        xfer(1, T_NS, 32'h2C, 0, 3'd2, 32'h0, 4'h0, K_RD, 32'hA3A3A3A3, "rd 0x2C");
        xfer(1, T_NS, 32'h1C, 0, 3'd2, 32'h0, 4'h0, K_RD, 32'hBEEF1111, "rd 0x1C untouched");
        xfer(1, T_NS, 32'h30, 0, 3'd2, 32'h0, 4'h0, K_RD, 32'hCAFEF00D, "rd 0x30");
        drain();

        // Reset in the wait state of a write
        xfer(1, T_NS, 32'h30, 1, 3'd2, 32'h12345678, 4'hF, K_WR, 0, "wr 0x30 aborted");
        #1;
        chk("mid-phase hreadyout", {31'b0, bus1.HREADYOUT}, 0);
        HRESETn = 1'b0;
        #1;
        chk("async reset hreadyout", {31'b0, bus1.HREADYOUT}, 1);
        chk("async reset hresp", {31'b0, bus1.HRESP}, 0);
        chk("async reset hrdata", bus1.HRDATA, 0);
        sb.delete();
        d_hsel = 1'b0; d_htrans = T_IDLE;
        @(negedge HCLK); @(negedge HCLK);
        HRESETn = 1'b1;
        xfer(1, T_NS, 32'h30, 0, 3'd2, 32'h0, 4'h0, K_RD, 32'hCAFEF00D, "rd 0x30 after reset");
        drain();

`ifdef AHB_SUB_EXCL_EN
        xfer(1, T_NS, 32'h40, 1, 3'd2, 32'h00000000, 4'hF, K_WR, 0, "wr 0x40 init");
        t_excl = 1'b1; t_master = 4'd2; t_exok = 1'b1;
        xfer(1, T_NS, 32'h40, 0, 3'd2, 32'h0, 4'h0, K_RD, 32'h00000000, "excl rd 0x40");
        xfer(1, T_NS, 32'h40, 1, 3'd2, 32'h00000001, 4'hF, K_WR, 0, "excl wr 0x40 ok");
        t_exok = 1'b0;
        xfer(1, T_NS, 32'h40, 1, 3'd2, 32'h00000002, 4'hF, K_WR, 0, "excl wr 0x40 fail");
        t_excl = 1'b0;
        xfer(1, T_NS, 32'h40, 0, 3'd2, 32'h0, 4'h0, K_RD, 32'h00000001, "rd 0x40");
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
